// File: rtl/pulse_chk_pkg.sv
// rtl/pulse_chk_pkg.sv - shared types, constants and window helper for the pulse period checker
//
// Contents:
//   state_t    checker FSM states (IDLE, ACQ, LOCK)
//   ERR_CNT_W  width of the saturating error/miss event counter
//   in_window  true when an interval lies within [P-TOL, P+TOL]
package pulse_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam int ERR_CNT_W = 8;

  // Unsigned acceptance test. When TOL >= P the lower bound would
  // underflow, so it is clamped to 1 (an interval is never shorter than 1).
  // The upper bound is computed one bit wider so P+TOL cannot wrap.
  function automatic logic in_window(input logic [31:0] interval,
                                     input logic [31:0] p,
                                     input logic [31:0] tol);
    logic [31:0] lo;
    logic [32:0] hi;
    lo = (tol >= p) ? 32'd1 : (p - tol);
    hi = {1'b0, p} + {1'b0, tol};
    return (interval >= lo) && ({1'b0, interval} <= hi);
  endfunction

endpackage

// File: rtl/pulse_period_checker_interval_counter.sv
// rtl/pulse_period_checker_interval_counter.sv - saturating clear-on-sig interval counter
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset, clears cnt
//   sig       pulse input; clears cnt in the cycle it is high
//   cnt       cycles elapsed since the last sig (saturates at all-ones)
//   interval  cnt+1, i.e. the interval that a sig in this cycle would measure
module interval_counter #(
  parameter int CBITS = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig,
  output logic [CBITS-1:0] cnt,
  output logic [CBITS-1:0] interval
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (sig) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + CBITS'(1);
    end
  end

  // Saturate rather than wrap so a long silence in IDLE never looks like a
  // short interval.
  assign interval = (cnt == '1) ? cnt : (cnt + CBITS'(1));

endmodule

// File: rtl/pulse_period_checker.sv
// rtl/pulse_period_checker.sv - receive-side health checker for a periodic strobe
//
// Measures the number of cycles between sig pulses and compares each interval
// against the expected period P = N+1 (+/- TOL). After LOCK_CNT consecutive
// good intervals the checker reports lock; early/late pulses raise err and a
// missing pulse (no sig by P+TOL) raises miss and returns to IDLE.
//
// Optional feature macro: PERIOD_STATS_EN adds min_period/max_period outputs.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset (priority over sig)
//   sig         one-cycle pulse from the generator, synchronous to clk
//   locked      high while in LOCK
//   err         one-cycle pulse: a measured interval was out of window
//   miss        one-cycle pulse: no sig seen by P+TOL while acquiring/locked
//   flg         high while cnt+1 lies inside the acceptance window
//   period      last measured interval (not updated by the first sig)
//   err_cnt     saturating count of err plus miss events
//   min_period  (PERIOD_STATS_EN) smallest interval since entering ACQ
//   max_period  (PERIOD_STATS_EN) largest interval since entering ACQ
module pulse_period_checker
  import pulse_chk_pkg::*;
#(
  parameter int N        = 200000,
  parameter int CBITS    = 18,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sig,
  output logic                 locked,
  output logic                 err,
  output logic                 miss,
  output logic                 flg,
  output logic [CBITS-1:0]     period,
`ifdef PERIOD_STATS_EN
  output logic [CBITS-1:0]     min_period,
  output logic [CBITS-1:0]     max_period,
`endif
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam longint CNT_CAP = (longint'(1) << CBITS) - 1;
  localparam logic [31:0] P_32   = 32'(N + 1);
  localparam logic [31:0] TOL_32 = 32'(TOL);
  // cnt value at which a missing pulse is declared (P+TOL cycles elapsed
  // without a sig since the last one).
  localparam logic [CBITS-1:0] MISS_AT = CBITS'(N + 1 + TOL);
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_CNT);

  if (CBITS < 2 || CBITS > 32) begin : g_bad_cbits
    $error("pulse_period_checker: CBITS must be in 2..32");
  end
  if (longint'(N) + longint'(TOL) + 2 > CNT_CAP) begin : g_bad_fit
    $error("pulse_period_checker: P+TOL+1 does not fit in CBITS");
  end
  if (LOCK_CNT < 1 || LOCK_CNT > 15) begin : g_bad_lock
    $error("pulse_period_checker: LOCK_CNT must be in 1..15");
  end
  if (N < 0 || TOL < 0) begin : g_bad_neg
    $error("pulse_period_checker: N and TOL must be non-negative");
  end

  logic [CBITS-1:0]     cnt;
  logic [CBITS-1:0]     interval;
  logic [CBITS-1:0]     nxt_interval;
  logic                 good_iv;
  logic                 nxt_flg;
  logic [ERR_CNT_W-1:0] err_cnt_inc;
  logic [3:0]           good;
  logic [3:0]           good_inc;
  state_t               state;

  interval_counter #(
    .CBITS (CBITS)
  ) u_interval_counter (
    .clk      (clk),
    .rst      (rst),
    .sig      (sig),
    .cnt      (cnt),
    .interval (interval)
  );

  // flg is registered but must track the live cnt, so it is computed from
  // the interval that will be presented in the following cycle.
  always_comb begin
    nxt_interval = interval;
    if (sig) begin
      nxt_interval = CBITS'(1);
    end else if (interval != '1) begin
      nxt_interval = interval + CBITS'(1);
    end
  end

  assign nxt_flg     = in_window(32'(nxt_interval), P_32, TOL_32);
  assign good_iv     = in_window(32'(interval), P_32, TOL_32);
  assign err_cnt_inc = (err_cnt == '1) ? err_cnt : (err_cnt + ERR_CNT_W'(1));
  assign good_inc    = good + 4'd1;

  assign locked = (state == LOCK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      good    <= '0;
      err     <= 1'b0;
      miss    <= 1'b0;
      flg     <= 1'b0;
      period  <= '0;
      err_cnt <= '0;
`ifdef PERIOD_STATS_EN
      min_period <= '1;
      max_period <= '0;
`endif
    end else begin
      err  <= 1'b0;
      miss <= 1'b0;
      flg  <= nxt_flg;

      unique case (state)
        IDLE: begin
          // First pulse only establishes the phase reference.
          if (sig) begin
            state <= ACQ;
            good  <= '0;
          end
        end

        ACQ, LOCK: begin
          if (sig) begin
            // A sig coinciding with the miss threshold is measured as a
            // (late) interval, never reported as a miss.
            period <= interval;
`ifdef PERIOD_STATS_EN
            if (interval < min_period) min_period <= interval;
            if (interval > max_period) max_period <= interval;
`endif
            if (good_iv) begin
              if (state == ACQ) begin
                good <= good_inc;
                if (good_inc == LOCK_N) begin
                  state <= LOCK;
                end
              end
            end else begin
              err     <= 1'b1;
              err_cnt <= err_cnt_inc;
              good    <= '0;
              state   <= ACQ;
            end
          end else if (cnt == MISS_AT) begin
            miss    <= 1'b1;
            err_cnt <= err_cnt_inc;
            good    <= '0;
            state   <= IDLE;
`ifdef PERIOD_STATS_EN
            min_period <= '1;
            max_period <= '0;
`endif
          end
        end

        default: begin
          state <= IDLE;
          good  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_period_checker.sv
// tb/tb_pulse_period_checker.sv - self-checking bench for pulse_period_checker
module tb_pulse_period_checker;

  localparam int NN = 10;
  localparam int CB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sig0 = 1'b0;
  logic sig1 = 1'b0;
  logic sig2 = 1'b0;

  logic          locked0, err0, miss0, flg0;
  logic [CB-1:0] period0;
  logic [7:0]    err_cnt0;
  logic          locked1, err1, miss1, flg1;
  logic [CB-1:0] period1;
  logic [7:0]    err_cnt1;
`ifdef PERIOD_STATS_EN
  logic [CB-1:0] min0, max0, min1, max1, min2, max2;
  logic          locked2, err2, miss2, flg2;
  logic [CB-1:0] period2;
  logic [7:0]    err_cnt2;
`endif

  int checks = 0;
  int errors = 0;
  int miss_hits0 = 0;
  int err_hits0 = 0;

  always #5 clk = ~clk;

  // TOL=0 instance
  pulse_period_checker #(.N(NN), .CBITS(CB), .TOL(0), .LOCK_CNT(4)) dut0 (
    .clk(clk), .rst(rst), .sig(sig0),
    .locked(locked0), .err(err0), .miss(miss0), .flg(flg0),
    .period(period0),
`ifdef PERIOD_STATS_EN
    .min_period(min0), .max_period(max0),
`endif
    .err_cnt(err_cnt0)
  );

  // TOL=1 instance
  pulse_period_checker #(.N(NN), .CBITS(CB), .TOL(1), .LOCK_CNT(4)) dut1 (
    .clk(clk), .rst(rst), .sig(sig1),
    .locked(locked1), .err(err1), .miss(miss1), .flg(flg1),
    .period(period1),
`ifdef PERIOD_STATS_EN
    .min_period(min1), .max_period(max1),
`endif
    .err_cnt(err_cnt1)
  );

`ifdef PERIOD_STATS_EN
  // TOL=2 instance so 9/11/13 intervals are all measured without a miss
  pulse_period_checker #(.N(NN), .CBITS(CB), .TOL(2), .LOCK_CNT(4)) dut2 (
    .clk(clk), .rst(rst), .sig(sig2),
    .locked(locked2), .err(err2), .miss(miss2), .flg(flg2),
    .period(period2),
    .min_period(min2), .max_period(max2),
    .err_cnt(err_cnt2)
  );
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic s0, input logic s1, input logic s2);
    @(negedge clk);
    sig0 = s0;
    sig1 = s1;
    sig2 = s2;
    @(posedge clk);
    #1;
    if (miss0) miss_hits0++;
    if (err0) err_hits0++;
  endtask

  // gap-1 idle cycles then one sig cycle on the selected instance
  task automatic pulse(input int which, input int gap);
    for (int j = 1; j < gap; j++) step(1'b0, 1'b0, 1'b0);
    step(which == 0, which == 1, which == 2);
  endtask

  typedef struct {
    int   gap;
    logic e_err;
    logic e_locked;
    int   e_period;
    int   e_cnt;
  } vec_t;

  vec_t tbl[13];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int miss_at, miss_n, flg_n, flg_at, flg_bad, flg_hits;
    int gaps1[4];
    int gaps2[4];

    //               gap err lck per cnt
    tbl[0]  = '{3,  1'b0, 1'b0, 0,  0};   // first sig: IDLE -> ACQ
    tbl[1]  = '{11, 1'b0, 1'b0, 11, 0};
    tbl[2]  = '{11, 1'b0, 1'b0, 11, 0};
    tbl[3]  = '{11, 1'b0, 1'b0, 11, 0};
    tbl[4]  = '{11, 1'b0, 1'b1, 11, 0};   // 5th sig: lock
    tbl[5]  = '{11, 1'b0, 1'b1, 11, 0};
    tbl[6]  = '{10, 1'b1, 1'b0, 10, 1};   // early pulse
    tbl[7]  = '{11, 1'b0, 1'b0, 11, 1};
    tbl[8]  = '{11, 1'b0, 1'b0, 11, 1};
    tbl[9]  = '{11, 1'b0, 1'b0, 11, 1};
    tbl[10] = '{11, 1'b0, 1'b1, 11, 1};   // relock after 4 good
    tbl[11] = '{12, 1'b1, 1'b0, 12, 2};   // sig on miss threshold: err, not miss
    tbl[12] = '{1,  1'b1, 1'b0, 1,  3};   // back-to-back

    // reset state
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("rst_locked0", locked0, 0);
    check("rst_err0", err0, 0);
    check("rst_miss0", miss0, 0);
    check("rst_flg0", flg0, 0);
    check("rst_period0", period0, 0);
    check("rst_errcnt0", err_cnt0, 0);
    check("rst_locked1", locked1, 0);
    rst = 1'b0;

    // table-driven sequence on dut0
    miss_hits0 = 0;
    err_hits0  = 0;
    for (int i = 0; i < 13; i++) begin
      pulse(0, tbl[i].gap);
      check($sformatf("tbl%0d_err", i), err0, tbl[i].e_err);
      check($sformatf("tbl%0d_locked", i), locked0, tbl[i].e_locked);
      check($sformatf("tbl%0d_period", i), period0, tbl[i].e_period);
      check($sformatf("tbl%0d_errcnt", i), err_cnt0, tbl[i].e_cnt);
    end
    check("tbl_miss_pulses", miss_hits0, 0);
    check("tbl_err_pulses", err_hits0, 3);

    // lock then let sig stop: exactly one miss when cnt reaches 11
    for (int i = 0; i < 4; i++) pulse(0, 11);
    check("preMiss_locked0", locked0, 1);
    miss_at = 0; miss_n = 0; flg_n = 0; flg_at = 0;
    for (int k = 1; k <= 25; k++) begin
      step(1'b0, 1'b0, 1'b0);
      if (miss0) begin miss_n++; miss_at = k; end
      if (flg0) begin flg_n++; flg_at = k; end
    end
    check("miss_count", miss_n, 1);
    check("miss_cycle", miss_at, 12);
    check("miss_flg_count", flg_n, 1);
    check("miss_flg_cycle", flg_at, 10);
    check("miss_locked0", locked0, 0);
    check("miss_errcnt0", err_cnt0, 4);
    pulse(0, 5);
    check("afterMiss_err0", err0, 0);
    check("afterMiss_period0", period0, 11);
    check("afterMiss_locked0", locked0, 0);

    // TOL=1: intervals 10,12,11,12 all good, flg only at cnt+1 in 10..12
    gaps1 = '{10, 12, 11, 12};
    flg_bad = 0; flg_hits = 0;
    pulse(1, 7);
    for (int i = 0; i < 4; i++) begin
      for (int j = 1; j < gaps1[i]; j++) begin
        step(1'b0, 1'b0, 1'b0);
        if (flg1) flg_hits++;
        if (flg1 !== ((j + 1 >= 10) && (j + 1 <= 12))) flg_bad++;
      end
      step(1'b0, 1'b1, 1'b0);
      check($sformatf("tol1_err%0d", i), err1, 0);
      check($sformatf("tol1_locked%0d", i), locked1, (i == 3));
    end
    check("tol1_flg_bad", flg_bad, 0);
    check("tol1_flg_hits", flg_hits, 9);
    check("tol1_period", period1, 12);
    check("tol1_errcnt", err_cnt1, 0);

    // reset mid-interval while locked, with sig high in the reset cycle
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    check("midrst_locked1", locked1, 0);
    check("midrst_err1", err1, 0);
    check("midrst_miss1", miss1, 0);
    check("midrst_flg1", flg1, 0);
    check("midrst_period1", period1, 0);
    check("midrst_errcnt1", err_cnt1, 0);
    check("midrst_errcnt0", err_cnt0, 0);
    pulse(1, 8);
    check("postrst_err1", err1, 0);
    check("postrst_locked1", locked1, 0);
    for (int i = 0; i < 4; i++) pulse(1, 11);
    check("postrst_relock1", locked1, 1);
    check("postrst_errcnt1", err_cnt1, 0);

    // saturation of err_cnt with 300 back-to-back bad intervals
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    pulse(0, 3);
    for (int k = 1; k <= 300; k++) begin
      step(1'b1, 1'b0, 1'b0);
      if (k == 254) check("sat_254", err_cnt0, 254);
      if (k == 255) check("sat_255", err_cnt0, 255);
    end
    check("sat_300", err_cnt0, 255);
    check("sat_err_still", err0, 1);

`ifdef PERIOD_STATS_EN
    check("stats0_min", min0, 1);
    check("stats0_max", max0, 1);
    gaps2 = '{11, 9, 13, 11};
    pulse(2, 4);
    check("stats2_min_init", min2, 255);
    check("stats2_max_init", max2, 0);
    for (int i = 0; i < 4; i++) pulse(2, gaps2[i]);
    check("stats2_min", min2, 9);
    check("stats2_max", max2, 13);
    check("stats2_errcnt", err_cnt2, 0);
    check("stats2_locked", locked2, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_period_checker.md
Name: pulse_period_checker

Overview:
- Receive-side monitor for the periodic strobe produced by the team's delay/pulse generator.
- Measures cycles between `sig` pulses and compares each interval against the expected period N+1.
- Acquires lock after consecutive good intervals and flags early, late or missing pulses.
- Sits downstream of the generator, or across a link from it, as a health checker.

Parameters:
- N, 200000: generator terminal count; expected interval P = N+1 cycles between pulses.
- CBITS, 18: counter and interval width; P+TOL+1 must fit in CBITS, else elaboration error.
- TOL, 0: allowed interval deviation in cycles (±TOL).
- LOCK_CNT, 4: consecutive good intervals needed to enter LOCK; range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- sig  input  1  pulse from generator, one cycle high per period, synchronous to clk.
- locked  output  1  high while in LOCK.
- err  output  1  one-cycle pulse: bad interval measured.
- miss  output  1  one-cycle pulse: no pulse seen by P+TOL.
- flg  output  1  high while cnt+1 is within [P-TOL, P+TOL] (acceptance window open).
- period  output  CBITS  last measured interval, updated on every sig after the first.
- err_cnt  output  8  saturating count of err plus miss events.

Behaviour:
- Reset: synchronous, active-high; rst has priority over sig.
  - All outputs 0; cnt=0; good=0; state=IDLE.
- Interval counter cnt:
  - Cleared to 0 in any cycle with sig=1; otherwise cnt+1, saturating at all-ones.
  - Measured interval is cnt+1 at the sig cycle, i.e. cycles since the previous sig.
- Good interval: P-TOL <= interval <= P+TOL, unsigned. If TOL >= P, lower bound clamps to 1.
- All outputs are registered and update on the edge that samples sig=1 (visible the next cycle).
- FSM states and transitions:
  - IDLE: waiting for first pulse. cnt is not checked; miss is never raised. On sig -> ACQ, good=0, period unchanged.
  - ACQ, on sig:
    - Good interval: good+1; if good+1 == LOCK_CNT -> LOCK.
    - Bad interval: err=1, good=0, stay ACQ.
  - LOCK, on sig:
    - Good interval: stay LOCK.
    - Bad interval: err=1, -> ACQ, good=0.
  - ACQ or LOCK, no sig and cnt == P+TOL: miss=1, -> IDLE.
- Exactly one of err or miss can pulse per cycle. A sig in the same cycle as the miss threshold counts as a sig, not a miss.
- err_cnt increments by 1 on err or miss and saturates at 255.
- locked is driven from state. It drops the cycle after the bad or missing event, or immediately on rst.
- Back-to-back sig (interval 1) is measured normally and is bad unless P-TOL <= 1.
- Reset mid-interval: state returns to IDLE; the next sig restarts acquisition with no err.

Optional Feature:
- Macro PERIOD_STATS_EN.
- Defined: adds outputs min_period and max_period, each CBITS wide.
  - Reset values: min=all-ones, max=0.
  - Updated on every measured interval in ACQ or LOCK, good or bad.
  - Cleared to reset values on entry to IDLE.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package pulse_chk_pkg: state enum (IDLE, ACQ, LOCK), ERR_CNT_W=8, function in_window(interval, P, TOL).
- One sub-module, interval_counter: the saturating, clear-on-sig counter, outputting cnt and interval.
- FSM, flags and statistics stay in the top module.

Test Plan (N=10, so P=11; TOL=0; LOCK_CNT=4 unless stated):
- Reset, then sig every 11 cycles × 6: first sig -> ACQ; locked=1 after the 5th sig; err=0, miss=0, period=11, err_cnt=0.
- While locked, one pulse arrives at interval 10, then 11s resume: err pulses once, locked=0, period=10, err_cnt=1; locked returns after 4 good intervals.
- While locked, sig stops: miss pulses exactly when cnt reaches 11 with no sig; state IDLE, locked=0, err_cnt+1; no further miss pulses.
- TOL=1, intervals 10, 12, 11, 12: all good; locked=1 after the 4th; flg high only at interval counts 10–12.
- rst asserted mid-interval while locked, then sig at an arbitrary time: all outputs 0; the next sig gives no err and re-enters ACQ.
- Force 300 bad intervals: err_cnt saturates at 255. With PERIOD_STATS_EN and mixed 9/11/13 intervals: min_period=9, max_period=13.
